// File: rtl/lora_cfg_sequencer_pkg.sv
// Shared definitions for the SX1278 boot-time configurator: register map,
// SPI frame helper and sequencer state encoding.
package lora_cfg_sequencer_pkg;

  localparam logic [6:0] REG_OPMODE     = 7'h01;
  localparam logic [6:0] REG_FRF_MSB    = 7'h06;
  localparam logic [6:0] REG_FRF_MID    = 7'h07;
  localparam logic [6:0] REG_FRF_LSB    = 7'h08;
  localparam logic [6:0] REG_PA_CONFIG  = 7'h09;
  localparam logic [6:0] REG_MODEM_CFG1 = 7'h1D;
  localparam logic [6:0] REG_MODEM_CFG2 = 7'h1E;
  localparam logic [6:0] REG_SYNC_WORD  = 7'h39;

  localparam logic SPI_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_LO,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic logic [15:0] make_frame(input logic [6:0] addr, input logic [7:0] data);
    return {SPI_WRITE, addr, data};
  endfunction

endpackage

// File: rtl/lora_cfg_sequencer_rom.sv
// Fixed SX1278 register-write table: entry index -> {addr, data}.
// Entries past the table return a write of 0 to address 0.
module lora_cfg_sequencer_rom
  import lora_cfg_sequencer_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0] index,
  output logic [6:0]       addr,
  output logic [7:0]       data
);

  always_comb begin
    addr = '0;
    data = '0;
    case (int'(index))
      0: begin addr = REG_OPMODE;     data = 8'h80; end
      1: begin addr = REG_FRF_MSB;    data = 8'h6C; end
      2: begin addr = REG_FRF_MID;    data = 8'h80; end
      3: begin addr = REG_FRF_LSB;    data = 8'h00; end
      4: begin addr = REG_PA_CONFIG;  data = 8'h8F; end
      5: begin addr = REG_MODEM_CFG1; data = 8'h72; end
      6: begin addr = REG_MODEM_CFG2; data = 8'h74; end
      7: begin addr = REG_OPMODE;     data = 8'h81; end
      default: begin addr = '0; data = '0; end
    endcase
  end

endmodule

// File: rtl/lora_cfg_sequencer.sv
// Walks the register table and hands each write to the SPI shifter as a
// 16-bit frame using a req/busy handshake with per-edge timeout.
module lora_cfg_sequencer
  import lora_cfg_sequencer_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES    = 8,
  parameter int unsigned IDX_W          = 4,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             spi_busy,
  output logic [15:0]      spi_word,
  output logic             spi_req,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] index
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

  state_e           state_q, state_d;
  logic [15:0]      spi_word_q, spi_word_d;
  logic             spi_req_q, spi_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [6:0] rom_addr;
  logic [7:0] rom_data;

  lora_cfg_sequencer_rom #(.IDX_W(IDX_W)) u_rom (
    .index (index_q),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  always_comb begin
    state_d    = state_q;
    spi_word_d = spi_word_q;
    spi_req_d  = spi_req_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    index_d    = index_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;

    // abort outranks everything, including a coincident start
    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      spi_req_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start && !abort) begin
            index_d = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
            busy_d  = 1'b1;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          spi_word_d = make_frame(rom_addr, rom_data);
          spi_req_d  = 1'b1;
          tmo_d      = '0;
          state_d    = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (spi_busy) begin
            spi_req_d = 1'b0;
            tmo_d     = '0;
            state_d   = ST_WAIT_LO;
          end else if (tmo_q == TMO_LAST) begin
            spi_req_d = 1'b0;
            busy_d    = 1'b0;
            error_d   = 1'b1;
            state_d   = ST_ERROR;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!spi_busy) begin
            gap_d   = '0;
            state_d = ST_GAP;
          end else if (tmo_q == TMO_LAST) begin
            busy_d  = 1'b0;
            error_d = 1'b1;
            state_d = ST_ERROR;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (index_q == IDX_LAST) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_DONE;
            end else begin
              index_d = index_q + IDX_W'(1);
              state_d = ST_LOAD;
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      spi_word_q <= '0;
      spi_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      index_q    <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      spi_word_q <= spi_word_d;
      spi_req_q  <= spi_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      index_q    <= index_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
    end
  end

  assign spi_word = spi_word_q;
  assign spi_req  = spi_req_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign index    = index_q;

endmodule

// File: tb/tb_lora_cfg_sequencer.sv
// Self-checking bench: behavioural SPI shifter plus a frame scoreboard fed
// from the expected register table, with directed corner-case sequences.
module tb_lora_cfg_sequencer;

  localparam int NUM_ENTRIES    = 8;
  localparam int GAP_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int SHIFT_CYCLES   = 32;

  localparam int M_NORMAL = 0;
  localparam int M_TIE0   = 1;
  localparam int M_STUCK  = 2;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] frame;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        spi_busy;
  logic [15:0] spi_word;
  logic        spi_req;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  index;

  int checks = 0;
  int errors = 0;

  vec_t tbl[NUM_ENTRIES];
  vec_t sb[$];

  int shf_mode  = M_NORMAL;
  int stuck_idx = 0;
  int accepts   = 0;
  int cyc       = 0;
  int fall_cyc  = 0;
  bit have_fall = 0;

  lora_cfg_sequencer #(
    .NUM_ENTRIES    (NUM_ENTRIES),
    .IDX_W          (4),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .spi_busy (spi_busy),
    .spi_word (spi_word),
    .spi_req  (spi_req),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .index    (index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_frames(input int count);
    for (int i = 0; i < count; i++) sb.push_back(tbl[i]);
  endtask

  task automatic wait_req(input int budget, output int n);
    n = 0;
    while (!spi_req && n < budget) begin
      tick();
      n++;
    end
    chk("req_wait_bound", 32'(spi_req), 32'd1);
  endtask

  task automatic wait_end(input int budget, output int n);
    n = 0;
    while (!done && !error && n < budget) begin
      tick();
      n++;
    end
    chk("end_wait_bound", 32'(n < budget), 32'd1);
  endtask

  // Behavioural shifter: raises busy one cycle after seeing req, holds it
  // SHIFT_CYCLES cycles; pops the scoreboard on every accepted frame.
  initial begin
    int   cnt;
    bit   stuck_now;
    vec_t e;
    spi_busy  = 1'b0;
    cnt       = 0;
    stuck_now = 0;
    forever begin
      tick();
      cyc++;
      if (spi_busy) begin
        if (!(shf_mode == M_STUCK && stuck_now)) begin
          cnt--;
          if (cnt == 0) begin
            spi_busy  = 1'b0;
            fall_cyc  = cyc;
            have_fall = 1;
            stuck_now = 0;
          end
        end
      end else if (spi_req && shf_mode != M_TIE0) begin
        spi_busy = 1'b1;
        cnt      = SHIFT_CYCLES;
        accepts++;
        if (have_fall) chk("gap_len", 32'((cyc - fall_cyc) >= GAP_CYCLES), 32'd1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=%0h expected=none", spi_word);
        end else begin
          e = sb.pop_front();
          chk("frame", 32'(spi_word), 32'(e.frame));
          chk("frame_index", 32'(index), 32'(e.idx));
          if (shf_mode == M_STUCK && e.idx == 4'(stuck_idx)) stuck_now = 1;
        end
      end
    end
  end

  initial begin
    int n;
    int acc0;
    int reqs;

    tbl[0] = '{4'd0, 16'h8180};
    tbl[1] = '{4'd1, 16'h866C};
    tbl[2] = '{4'd2, 16'h8780};
    tbl[3] = '{4'd3, 16'h8800};
    tbl[4] = '{4'd4, 16'h898F};
    tbl[5] = '{4'd5, 16'h9D72};
    tbl[6] = '{4'd6, 16'h9E74};
    tbl[7] = '{4'd7, 16'h8181};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    chk("rst_spi_word", 32'(spi_word), 32'd0);
    chk("rst_spi_req", 32'(spi_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_index", 32'(index), 32'd0);
    reset = 1'b0;
    tick();

    // Nominal run; a second start mid-run must be ignored
    shf_mode  = M_NORMAL;
    have_fall = 0;
    acc0      = accepts;
    push_frames(NUM_ENTRIES);
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_req(20, n);
    chk("req_latency", 32'(n), 32'd1);
    chk("first_word", 32'(spi_word), 32'h8180);
    repeat (50) tick();
    pulse_start();
    wait_end(2000, n);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_busy", 32'(busy), 32'd0);
    chk("nom_error", 32'(error), 32'd0);
    chk("nom_index", 32'(index), 32'd7);
    chk("nom_last_word", 32'(spi_word), 32'h8181);
    repeat (10) tick();
    chk("nom_frames", 32'(accepts - acc0), 32'd8);
    chk("nom_sb_empty", 32'(sb.size()), 32'd0);

    // start and abort together from DONE: abort wins, done untouched
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("prio_busy", 32'(busy), 32'd0);
    chk("prio_done", 32'(done), 32'd1);
    repeat (5) tick();
    chk("prio_busy_later", 32'(busy), 32'd0);
    chk("prio_req_later", 32'(spi_req), 32'd0);

    // Handshake timeout: shifter never answers
    shf_mode = M_TIE0;
    pulse_start();
    chk("to_done_cleared", 32'(done), 32'd0);
    wait_req(20, n);
    n = 0;
    while (!error && n < 200) begin
      tick();
      n++;
    end
    chk("to_cycles", 32'(n), 32'(TIMEOUT_CYCLES));
    chk("to_error", 32'(error), 32'd1);
    chk("to_index", 32'(index), 32'd0);
    chk("to_req", 32'(spi_req), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);

    // Busy stuck high on entry 3
    shf_mode  = M_STUCK;
    stuck_idx = 3;
    have_fall = 0;
    push_frames(4);
    pulse_start();
    chk("stuck_error_cleared", 32'(error), 32'd0);
    wait_end(1000, n);
    chk("stuck_error", 32'(error), 32'd1);
    chk("stuck_index", 32'(index), 32'd3);
    chk("stuck_busy", 32'(busy), 32'd0);
    chk("stuck_sb_empty", 32'(sb.size()), 32'd0);
    shf_mode = M_NORMAL;
    repeat (50) tick();

    // Abort while waiting for busy to fall on entry 2
    have_fall = 0;
    acc0      = accepts;
    push_frames(3);
    pulse_start();
    n = 0;
    while ((accepts - acc0) < 3 && n < 1000) begin
      tick();
      n++;
    end
    chk("abort_reach_entry2", 32'(accepts - acc0), 32'd3);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req", 32'(spi_req), 32'd0);
    chk("abort_error", 32'(error), 32'd0);
    reqs = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (spi_req) reqs++;
    end
    chk("abort_no_req", 32'(reqs), 32'd0);
    chk("abort_no_accept", 32'(accepts - acc0), 32'd3);

    have_fall = 0;
    push_frames(NUM_ENTRIES);
    pulse_start();
    wait_req(20, n);
    chk("rerun_first_word", 32'(spi_word), 32'h8180);
    wait_end(2000, n);
    chk("rerun_done", 32'(done), 32'd1);

    // Reset while sitting in ISSUE
    shf_mode = M_TIE0;
    pulse_start();
    wait_req(20, n);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("mrst_spi_word", 32'(spi_word), 32'd0);
    chk("mrst_spi_req", 32'(spi_req), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_error", 32'(error), 32'd0);
    chk("mrst_index", 32'(index), 32'd0);
    reset    = 1'b0;
    shf_mode = M_NORMAL;
    tick();
    have_fall = 0;
    acc0      = accepts;
    push_frames(NUM_ENTRIES);
    pulse_start();
    wait_end(2000, n);
    chk("mrst_rerun_done", 32'(done), 32'd1);
    chk("mrst_rerun_index", 32'(index), 32'd7);
    repeat (10) tick();
    chk("mrst_rerun_frames", 32'(accepts - acc0), 32'd8);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
